// File: rtl/hdma_ctrl.sv
// CGB VRAM DMA engine (FF51-FF55). Decodes CPU register writes and runs either a
// general-purpose copy (all blocks back to back) or an H-blank copy (one block per
// hblank_start pulse) into VRAM, stalling the CPU via DMA_start while it owns the bus.
module hdma_ctrl #(
  parameter int unsigned BLOCK_BYTES = 16
) (
  input  logic        clk4_2,
  input  logic        reset_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  output logic [7:0]  cpu_rdata,
  input  logic        hblank_start,
  input  logic        lcd_on,
  output logic        DMA_start,
  output logic        GDMA_finished,
  output logic [15:0] dma_src_addr,
  output logic        dma_rd,
  input  logic [7:0]  dma_rdata,
  output logic [15:0] dma_dst_addr,
  output logic [7:0]  dma_wdata,
  output logic        dma_we
);

  localparam int unsigned     CntW    = $clog2(BLOCK_BYTES);
  localparam logic [CntW-1:0] CntLast = CntW'(BLOCK_BYTES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StGdmaRd,
    StGdmaWr,
    StHdmaWait,
    StHdmaRd,
    StHdmaWr,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     src_q, src_d;
  logic [12:0]     dst_q, dst_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      blocks_q, blocks_d;
  logic [7:0]      byte_q, byte_d;
  logic            dma_start_q, dma_start_d;

  logic            wr_en;
  logic            wr_ff55;
  logic [7:0]      blocks_reload;
  logic            last_byte;
  logic            status_idle;

  // CPU register writes are locked out while the engine owns the bus.
  assign wr_en         = cpu_we && !dma_start_q;
  assign wr_ff55       = wr_en && (cpu_addr == 16'hFF55);
  assign blocks_reload = {1'b0, cpu_wdata[6:0]} + 8'd1;
  assign last_byte     = (cnt_q == CntLast);

  // State and datapath registers; reset aborts any burst with no completion pulse.
  always_ff @(posedge clk4_2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      src_q       <= '0;
      dst_q       <= '0;
      cnt_q       <= '0;
      blocks_q    <= '0;
      byte_q      <= '0;
      dma_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      cnt_q       <= cnt_d;
      blocks_q    <= blocks_d;
      byte_q      <= byte_d;
      dma_start_q <= dma_start_d;
    end
  end

  // Next-state: address register writes first, then the transfer sequencer.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    cnt_d    = cnt_q;
    blocks_d = blocks_q;
    byte_d   = byte_q;

    // Applied before the FSM so a same-cycle hblank starts from the new addresses.
    if (wr_en) begin
      case (cpu_addr)
        16'hFF51: src_d[15:8] = cpu_wdata;
        16'hFF52: src_d[7:0]  = {cpu_wdata[7:4], 4'h0};
        16'hFF53: dst_d[12:8] = cpu_wdata[4:0];
        16'hFF54: dst_d[7:0]  = {cpu_wdata[7:4], 4'h0};
        default: ;
      endcase
    end

    case (state_q)
      StIdle: begin
        if (wr_ff55) begin
          blocks_d = blocks_reload;
          if (!cpu_wdata[7]) begin
            state_d = StGdmaRd;
          end else if (lcd_on) begin
            state_d = StHdmaWait;
          end else begin
            // With the LCD off no hblank will ever come, so copy one block now.
            state_d = StHdmaRd;
          end
        end
      end

      StHdmaWait: begin
        // A cancel or reload write takes priority over a coincident hblank.
        if (wr_ff55) begin
          if (!cpu_wdata[7]) begin
            state_d = StIdle;
          end else begin
            blocks_d = blocks_reload;
          end
        end else if (hblank_start && lcd_on) begin
          state_d = StHdmaRd;
        end
      end

      StGdmaRd: begin
        byte_d  = dma_rdata;
        state_d = StGdmaWr;
      end

      StHdmaRd: begin
        byte_d  = dma_rdata;
        state_d = StHdmaWr;
      end

      StGdmaWr, StHdmaWr: begin
        src_d = src_q + 16'd1;
        dst_d = dst_q + 13'd1;
        if (last_byte) begin
          cnt_d    = '0;
          blocks_d = blocks_q - 8'd1;
          if ((state_q == StHdmaWr) || (blocks_q == 8'd1)) begin
            state_d = StDone;
          end else begin
            state_d = StGdmaRd;
          end
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = (state_q == StHdmaWr) ? StHdmaRd : StGdmaRd;
        end
      end

      StDone: begin
        // Only an H-blank copy can leave blocks behind at a burst end.
        state_d = (blocks_q != 8'd0) ? StHdmaWait : StIdle;
      end

      default: state_d = StIdle;
    endcase

    dma_start_d = (state_d == StGdmaRd) || (state_d == StGdmaWr) ||
                  (state_d == StHdmaRd) || (state_d == StHdmaWr);
  end

  // Bus strobes decode from state; addresses and data are zero when not strobed.
  always_comb begin
    dma_rd        = (state_q == StGdmaRd) || (state_q == StHdmaRd);
    dma_we        = (state_q == StGdmaWr) || (state_q == StHdmaWr);
    DMA_start     = dma_start_q;
    GDMA_finished = (state_q == StDone);
    dma_src_addr  = dma_rd ? src_q : 16'h0000;
    dma_dst_addr  = dma_we ? {3'b100, dst_q} : 16'h0000;
    dma_wdata     = dma_we ? byte_q : 8'h00;
  end

  // FF55 status: bit 7 set when nothing is pending; low bits are blocks remaining minus one.
  // After a completed copy blocks is zero, so this naturally reads 0xFF.
  assign status_idle = (state_q == StIdle) || (blocks_q == 8'd0);

  // CPU read mux; only FF55 is readable.
  always_comb begin
    cpu_rdata = 8'hFF;
    if (cpu_addr == 16'hFF55) begin
      cpu_rdata = {status_idle, blocks_q[6:0] - 7'd1};
    end
  end

endmodule

// File: tb/tb_hdma_ctrl.sv
// Self-checking bench for hdma_ctrl: a transaction-level model predicts the VRAM write
// stream, busy-cycle counts and FF55 status; a per-cycle monitor checks the DUT against it.
module tb_hdma_ctrl;

  logic        clk4_2 = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_wdata = 8'h00;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_rdata;
  logic        hblank_start = 1'b0;
  logic        lcd_on = 1'b1;
  logic        DMA_start;
  logic        GDMA_finished;
  logic [15:0] dma_src_addr;
  logic        dma_rd;
  logic [7:0]  dma_rdata;
  logic [15:0] dma_dst_addr;
  logic [7:0]  dma_wdata;
  logic        dma_we;

  hdma_ctrl #(.BLOCK_BYTES(16)) dut (
    .clk4_2        (clk4_2),
    .reset_n       (reset_n),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_we        (cpu_we),
    .cpu_rdata     (cpu_rdata),
    .hblank_start  (hblank_start),
    .lcd_on        (lcd_on),
    .DMA_start     (DMA_start),
    .GDMA_finished (GDMA_finished),
    .dma_src_addr  (dma_src_addr),
    .dma_rd        (dma_rd),
    .dma_rdata     (dma_rdata),
    .dma_dst_addr  (dma_dst_addr),
    .dma_wdata     (dma_wdata),
    .dma_we        (dma_we)
  );

  always #5 clk4_2 = ~clk4_2;

  int total = 0;
  int bad = 0;
  int ds_cnt = 0;
  int fin_cnt = 0;
  int wr_cnt = 0;
  logic [15:0] last_rd = 16'h0000;
  logic [15:0] last_wr = 16'h0000;

  // Reference model state
  logic [15:0] m_src = 16'h0000;
  logic [12:0] m_dst = 13'h0000;
  int          m_blocks = 0;
  bit          m_wait = 1'b0;
  logic [15:0] exp_addr[$];
  logic [7:0]  exp_data[$];

  function automatic logic [7:0] mem_at(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
  endfunction

  // Source memory answers reads with a fixed address-derived pattern.
  always_comb dma_rdata = dma_rd ? mem_at(dma_src_addr) : 8'h00;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] status_exp();
    logic [7:0] r;
    r = {1'b0, 7'(m_blocks - 1)};
    if (!m_wait) r[7] = 1'b1;
    return r;
  endfunction

  task automatic push_block();
    for (int i = 0; i < 16; i++) begin
      exp_addr.push_back({3'b100, m_dst});
      exp_data.push_back(mem_at(m_src));
      m_src = m_src + 16'd1;
      m_dst = m_dst + 13'd1;
    end
  endtask

  // Per-cycle monitor
  always @(negedge clk4_2) begin : cmp
    logic [15:0] ea;
    logic [7:0]  ed;
    if (reset_n) begin
      if (DMA_start) ds_cnt++;
      if (dma_rd) last_rd = dma_src_addr;
      if (GDMA_finished) begin
        fin_cnt++;
        check("done_quiet", int'({DMA_start, dma_rd, dma_we}), 0);
      end
      if (dma_we) begin
        wr_cnt++;
        last_wr = dma_dst_addr;
        check("we_exclusive", int'({dma_rd, DMA_start}), 1);
        if (exp_addr.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h want none",
                   dma_dst_addr, dma_wdata);
        end else begin
          ea = exp_addr.pop_front();
          ed = exp_data.pop_front();
          check("wr_addr", int'(dma_dst_addr), int'(ea));
          check("wr_data", int'(dma_wdata), int'(ed));
        end
      end
    end
  end

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(posedge clk4_2); #1;
    cpu_addr = a; cpu_wdata = d; cpu_we = 1'b1;
    @(posedge clk4_2); #1;
    cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
  endtask

  task automatic check55(input string name);
    logic [7:0] v;
    @(negedge clk4_2);
    cpu_addr = 16'hFF55;
    #1 v = cpu_rdata;
    cpu_addr = 16'h0000;
    check(name, int'(v), int'(status_exp()));
  endtask

  task automatic set_src(input logic [15:0] s);
    cpu_write(16'hFF51, s[15:8]);
    cpu_write(16'hFF52, s[7:0]);
    m_src = {s[15:4], 4'h0};
  endtask

  task automatic set_dst(input logic [12:0] d);
    cpu_write(16'hFF53, {3'($urandom), d[12:8]});
    cpu_write(16'hFF54, d[7:0]);
    m_dst = {d[12:4], 4'h0};
  endtask

  task automatic pulse_hblank();
    @(posedge clk4_2); #1 hblank_start = 1'b1;
    @(posedge clk4_2); #1 hblank_start = 1'b0;
  endtask

  task automatic quiet(input int cyc, input string name);
    int ds0 = ds_cnt;
    int wr0 = wr_cnt;
    repeat (cyc) @(posedge clk4_2);
    #1;
    check(name, (ds_cnt - ds0) + (wr_cnt - wr0), 0);
  endtask

  // Waits (bounded) for the burst-end pulse, optionally poking FF51 mid-burst.
  task automatic finish_burst(input int nblk, input int ds0, input int fin0, input int wr0,
                              input bit poke);
    for (int i = 0; i < 32 * nblk + 8; i++) begin
      @(posedge clk4_2); #1;
      if (poke && i == 3) begin
        cpu_addr = 16'hFF51; cpu_wdata = 8'h5A; cpu_we = 1'b1;
      end else begin
        cpu_we = 1'b0; cpu_addr = 16'h0000;
      end
      if (fin_cnt != fin0) break;
    end
    cpu_we = 1'b0; cpu_addr = 16'h0000;
    @(posedge clk4_2); #1;
    check("fin_pulses", fin_cnt - fin0, 1);
    check("busy_cycles", ds_cnt - ds0, 32 * nblk);
    check("bytes", wr_cnt - wr0, 16 * nblk);
    check("queue_empty", exp_addr.size(), 0);
  endtask

  task automatic do_gdma(input logic [7:0] d, input bit poke);
    int n = int'(d[6:0]) + 1;
    int ds0 = ds_cnt;
    int fin0 = fin_cnt;
    int wr0 = wr_cnt;
    for (int b = 0; b < n; b++) push_block();
    m_blocks = 0;
    m_wait = 1'b0;
    cpu_write(16'hFF55, d);
    check("gdma_start", int'(DMA_start), 1);
    finish_burst(n, ds0, fin0, wr0, poke);
    check55("gdma_status");
  endtask

  task automatic do_hblank();
    int ds0 = ds_cnt;
    int fin0 = fin_cnt;
    int wr0 = wr_cnt;
    push_block();
    m_blocks--;
    pulse_hblank();
    check("hdma_start", int'(DMA_start), 1);
    finish_burst(1, ds0, fin0, wr0, 1'b0);
    m_wait = (m_blocks != 0);
    check55("hdma_status");
  endtask

  task automatic hdma_arm(input logic [7:0] d);
    m_blocks = int'(d[6:0]) + 1;
    m_wait = 1'b1;
    cpu_write(16'hFF55, d);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] v;
    int ds0, fin0, wr0;

    // Reset state
    #2;
    check("rst_outputs", int'({DMA_start, GDMA_finished, dma_rd, dma_we, dma_src_addr,
                               dma_dst_addr, dma_wdata}), 0);
    cpu_addr = 16'hFF54;
    #1 check("rst_rdata_other", int'(cpu_rdata), 8'hFF);
    cpu_addr = 16'hFF55;
    #1 check("rst_rdata_ff55", int'(cpu_rdata), 8'hFF);
    cpu_addr = 16'h0000;
    @(negedge clk4_2) reset_n = 1'b1;

    // GDMA one block from 0xC000 to 0x8000
    set_src(16'hC000);
    set_dst(13'h0000);
    do_gdma(8'h00, 1'b0);
    check("g1_last_wr", int'(last_wr), 16'h800F);
    check("g1_last_rd", int'(last_rd), 16'hC00F);

    // GDMA 3 blocks, low source nibble forced to zero, mid-burst write ignored
    set_src(16'h1234);
    set_dst(13'h0000);
    do_gdma(8'h02, 1'b1);
    check("g3_last_rd", int'(last_rd), 16'h125F);
    check("g3_last_wr", int'(last_wr), 16'h802F);

    // HDMA 2 blocks
    set_src(16'h4000);
    hdma_arm(8'h81);
    quiet(6, "hdma_idle_wait");
    check55("hdma_armed");
    do_hblank();
    do_hblank();
    pulse_hblank();
    quiet(8, "extra_hblank");

    // HDMA cancel: cancel coincides with an hblank and must win
    hdma_arm(8'h83);
    do_hblank();
    ds0 = ds_cnt;
    @(posedge clk4_2); #1;
    cpu_addr = 16'hFF55; cpu_wdata = 8'h00; cpu_we = 1'b1; hblank_start = 1'b1;
    @(posedge clk4_2); #1;
    cpu_we = 1'b0; cpu_addr = 16'h0000; hblank_start = 1'b0;
    m_wait = 1'b0;
    check55("cancel_status");
    cpu_addr = 16'hFF55;
    #1 v = cpu_rdata;
    cpu_addr = 16'h0000;
    check("cancel_literal", int'(v), 8'h82);
    pulse_hblank();
    quiet(6, "cancel_quiet");
    check("cancel_no_busy", ds_cnt - ds0, 0);

    // Reload in wait, then an address write coinciding with the hblank
    hdma_arm(8'h85);
    hdma_arm(8'h80);
    check55("reload_status");
    ds0 = ds_cnt; fin0 = fin_cnt; wr0 = wr_cnt;
    @(posedge clk4_2); #1;
    cpu_addr = 16'hFF51; cpu_wdata = 8'h40; cpu_we = 1'b1; hblank_start = 1'b1;
    m_src = {8'h40, m_src[7:0]};
    push_block();
    m_blocks--;
    @(posedge clk4_2); #1;
    cpu_we = 1'b0; cpu_addr = 16'h0000; hblank_start = 1'b0;
    check("coinc_start", int'(DMA_start), 1);
    finish_burst(1, ds0, fin0, wr0, 1'b0);
    m_wait = 1'b0;
    check55("coinc_status");

    // LCD off: first block runs at once, later hblanks need the LCD on
    lcd_on = 1'b0;
    ds0 = ds_cnt; fin0 = fin_cnt; wr0 = wr_cnt;
    push_block();
    hdma_arm(8'h81);
    m_blocks--;
    check("lcdoff_start", int'(DMA_start), 1);
    finish_burst(1, ds0, fin0, wr0, 1'b0);
    check55("lcdoff_status");
    pulse_hblank();
    quiet(6, "lcdoff_hblank");
    lcd_on = 1'b1;
    do_hblank();

    // Destination wrap
    set_src(16'h2000);
    set_dst(13'h1FF0);
    do_gdma(8'h01, 1'b0);
    check("wrap_last_wr", int'(last_wr), 16'h800F);

    // Randomized copies
    for (int it = 0; it < 8; it++) begin
      int n = $urandom_range(1, 3);
      set_src(16'($urandom));
      set_dst(13'($urandom));
      if ($urandom_range(0, 1) == 0) begin
        do_gdma({1'b0, 7'(n - 1)}, 1'($urandom));
      end else begin
        hdma_arm({1'b1, 7'(n - 1)});
        for (int b = 0; b < n; b++) begin
          repeat ($urandom_range(0, 4)) @(posedge clk4_2);
          if ($urandom_range(0, 2) == 0) set_dst(13'($urandom));
          do_hblank();
        end
      end
    end

    // Reset in the middle of a GDMA
    set_src(16'hC000);
    set_dst(13'h0000);
    fin0 = fin_cnt;
    push_block();
    push_block();
    cpu_write(16'hFF55, 8'h01);
    repeat (9) @(posedge clk4_2);
    #1 reset_n = 1'b0;
    #1 check("rst_mid_outputs", int'({DMA_start, dma_we, dma_rd, GDMA_finished}), 0);
    exp_addr.delete();
    exp_data.delete();
    m_src = 16'h0000; m_dst = 13'h0000; m_blocks = 0; m_wait = 1'b0;
    repeat (3) @(posedge clk4_2);
    @(negedge clk4_2) reset_n = 1'b1;
    quiet(6, "rst_mid_quiet");
    check("rst_mid_no_fin", fin_cnt - fin0, 0);
    check55("rst_mid_status");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
